// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the IF/MA data-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MA_X     = 2'b00,
    MA_LOAD  = 2'b01,
    MA_STORE = 2'b10
  } ma_mode_t;

  // Bit 2 selects zero extension; bits [1:0] give the access width.
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } ma_size_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_IF   = 2'b01,
    OWNER_MA   = 2'b10
  } mem_owner_t;

  localparam logic [3:0] MEM_WE_NONE = 4'b0000;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(ma_size_t sz, logic [1:0] off);
    case (sz)
      SZ_H, SZ_HU: is_misaligned = off[0];
      SZ_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Unshifted byte-lane mask for a store of the given width.
  function automatic logic [3:0] store_lanes(ma_size_t sz);
    case (sz)
      SZ_B, SZ_BU: store_lanes = 4'b0001;
      SZ_H, SZ_HU: store_lanes = 4'b0011;
      default:     store_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_load_align.sv
// Picks the addressed byte/half out of a read word and extends it.
module load_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  ma_size_t    size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  assign shifted = mem_rdata_i >> {offset_i, 3'b000};

  // Extend the selected lane; a word load is always aligned so passes through.
  always_comb begin
    rdata_o = mem_rdata_i;
    case (size_i)
      SZ_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU:   rdata_o = {24'h0, shifted[7:0]};
      SZ_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      SZ_HU:   rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch (IF) and the
// memory-access stage (MA). MA normally wins; a starvation counter forces
// one IF grant after STARVE_LIMIT consecutive denials.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  ma_req_i,
  input  ma_mode_t              ma_mode_i,
  input  ma_size_t              ma_size_i,
  input  logic [31:0]           ma_addr_i,
  input  logic [31:0]           ma_wdata_i,
  output logic                  ma_gnt_o,
  output logic                  ma_misaligned_o,
  output logic                  ma_rvalid_o,
  output logic [31:0]           ma_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int              CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  mem_owner_t    owner_q, owner_d;
  ma_size_t      size_q;
  logic [1:0]    off_q;

  logic ma_eff, force_if, ma_win, ma_mis, ma_acc, if_win, ma_store;
  logic [1:0] ma_off;

  assign ma_off   = ma_addr_i[1:0];
  assign ma_eff   = ma_req_i && (ma_mode_i != MA_X);
  assign force_if = if_req_i && (starve_q == STARVE_MAX);

  // Grants are gated by reset so nothing is accepted while it is held.
  assign ma_win   = reset_n_i && ma_eff && !force_if;
  assign ma_mis   = ma_win && is_misaligned(ma_size_i, ma_off);
  assign ma_acc   = ma_win && !ma_mis;
  assign ma_store = ma_acc && (ma_mode_i == MA_STORE);
  // A misaligned MA request leaves the port free, so IF can take it.
  assign if_win   = reset_n_i && if_req_i && !ma_acc;

  assign ma_gnt_o        = ma_win;
  assign ma_misaligned_o = ma_mis;
  assign if_gnt_o        = if_win;

  // Drive the memory port from whichever requester actually uses it.
  always_comb begin
    mem_en_o    = ma_acc || if_win;
    mem_we_o    = MEM_WE_NONE;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ma_acc) begin
      mem_addr_o = ma_addr_i[ADDR_WIDTH+1:2];
      if (ma_store) begin
        mem_we_o    = store_lanes(ma_size_i) << ma_off;
        mem_wdata_o = ma_wdata_i << {ma_off, 3'b000};
      end
    end else if (if_win) begin
      mem_addr_o = if_addr_i[ADDR_WIDTH+1:2];
    end
  end

  // Next owner of the read data coming back next cycle; stores return nothing.
  always_comb begin
    owner_d = OWNER_NONE;
    if (ma_acc && !ma_store) owner_d = OWNER_MA;
    else if (if_win)         owner_d = OWNER_IF;
  end

  // Count consecutive denied IF cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_win)       starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  // Owner and starvation state; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      owner_q  <= OWNER_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Load format captured on an accepted MA access.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      size_q <= SZ_W;
      off_q  <= 2'b00;
    end else if (ma_acc) begin
      size_q <= ma_size_i;
      off_q  <= ma_off;
    end
  end

  logic [31:0] ma_aligned;

  load_align u_load_align (
    .mem_rdata_i (mem_rdata_i),
    .size_i      (size_q),
    .offset_i    (off_q),
    .rdata_o     (ma_aligned)
  );

  assign if_rvalid_o = (owner_q == OWNER_IF);
  assign ma_rvalid_o = (owner_q == OWNER_MA);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ma_rdata_o  = ma_rvalid_o ? ma_aligned : '0;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_WIDTH+2], if_addr_i[1:0],
                              ma_addr_i[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a behavioural BRAM and a
// response scoreboard per requester.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ma_req;
  ma_mode_t      ma_mode;
  ma_size_t      ma_size;
  logic [31:0]   ma_addr, ma_wdata;
  logic          ma_gnt, ma_mis, ma_rvalid;
  logic [31:0]   ma_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] if_q[$];
  logic [31:0] ma_q[$];
  logic [31:0] ram [0:(1<<AW)-1];

  mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ma_req_i(ma_req), .ma_mode_i(ma_mode), .ma_size_i(ma_size),
    .ma_addr_i(ma_addr), .ma_wdata_i(ma_wdata), .ma_gnt_o(ma_gnt),
    .ma_misaligned_o(ma_mis), .ma_rvalid_o(ma_rvalid), .ma_rdata_o(ma_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM with byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Scoreboard: every response must match the oldest expected entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (if_rvalid) begin
      n_vec = n_vec + 1;
      if (if_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL if_rvalid_unexpected got rdata=%h want no response", if_rdata);
      end else begin
        e = if_q.pop_front();
        if (if_rdata !== e) begin
          n_err = n_err + 1;
          $display("FAIL if_rdata got %h want %h", if_rdata, e);
        end
      end
    end
    if (ma_rvalid) begin
      n_vec = n_vec + 1;
      if (ma_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL ma_rvalid_unexpected got rdata=%h want no response", ma_rdata);
      end else begin
        e = ma_q.pop_front();
        if (ma_rdata !== e) begin
          n_err = n_err + 1;
          $display("FAIL ma_rdata got %h want %h", ma_rdata, e);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = '0;
    ma_req = 1'b0; ma_mode = MA_X; ma_size = SZ_W;
    ma_addr = '0; ma_wdata = '0;
  endtask

  task automatic drive_ma(input ma_mode_t m, input ma_size_t s,
                          input logic [31:0] a, input logic [31:0] d);
    ma_req = 1'b1; ma_mode = m; ma_size = s; ma_addr = a; ma_wdata = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    drive_ma(MA_STORE, SZ_W, 32'h100, 32'hFFFF_FFFF);
    #6;
    n_vec++;
    if ({if_gnt, ma_gnt, ma_mis, mem_en} !== 4'b0) begin
      n_err++; $display("FAIL reset_grants got %b want 0000", {if_gnt, ma_gnt, ma_mis, mem_en});
    end
    n_vec++;
    if (mem_we !== 4'b0000) begin
      n_err++; $display("FAIL reset_we got %b want 0000", mem_we);
    end
    n_vec++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_port_data got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    n_vec++;
    if ({if_rvalid, ma_rvalid, if_rdata, ma_rdata} !== '0) begin
      n_err++; $display("FAIL reset_resp got ifv=%b mav=%b ifd=%h mad=%h want 0",
                        if_rvalid, ma_rvalid, if_rdata, ma_rdata);
    end
    idle();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] a_t[2] = '{32'h10, 32'h23};
    logic [31:0] w_t[2] = '{32'h4,  32'h8};
    logic [31:0] d_t[2] = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      if_req = 1'b1; if_addr = a_t[i];
      settle();
      n_vec++;
      if ({if_gnt, ma_gnt, mem_en} !== 3'b101) begin
        n_err++; $display("FAIL fetch_gnt got if=%b ma=%b en=%b want 1 0 1", if_gnt, ma_gnt, mem_en);
      end
      n_vec++;
      if (mem_addr !== w_t[i][AW-1:0] || mem_we !== 4'b0000) begin
        n_err++; $display("FAIL fetch_port got addr=%h we=%b want %h 0000", mem_addr, mem_we, w_t[i]);
      end
      if_q.push_back(d_t[i]);
    end
    next_cyc(); idle(); settle();
  endtask

  task automatic test_simultaneous();
    ram[12'h40] = 32'hDEAD_BEEF;
    next_cyc();
    if_req = 1'b1; if_addr = 32'h10;
    drive_ma(MA_LOAD, SZ_W, 32'h100, '0);
    settle();
    n_vec++;
    if ({ma_gnt, if_gnt} !== 2'b10) begin
      n_err++; $display("FAIL simul_gnt got ma=%b if=%b want 1 0", ma_gnt, if_gnt);
    end
    n_vec++;
    if (mem_addr !== 12'h040) begin
      n_err++; $display("FAIL simul_addr got %h want 040", mem_addr);
    end
    ma_q.push_back(32'hDEAD_BEEF);
    next_cyc(); idle(); settle();
    n_vec++;
    if ({ma_rvalid, if_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL simul_rvalid got ma=%b if=%b want 1 0", ma_rvalid, if_rvalid);
    end
  endtask

  task automatic test_load_ext();
    ma_size_t    s_t[9] = '{SZ_B, SZ_BU, SZ_HU, SZ_HU, SZ_H, SZ_B, SZ_H, SZ_HU, SZ_W};
    logic [31:0] a_t[9] = '{32'h103, 32'h103, 32'h102, 32'h202, 32'h202,
                            32'h101, 32'h200, 32'h200, 32'h200};
    logic [31:0] e_t[9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_807F,
                            32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0055,
                            32'hFFFF_8001, 32'h0000_8001, 32'hBEEF_8001};
    ram[12'h40] = 32'h807F_5501;
    ram[12'h80] = 32'hBEEF_8001;
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      drive_ma(MA_LOAD, s_t[i], a_t[i], '0);
      settle();
      n_vec++;
      if ({ma_gnt, ma_mis, mem_en} !== 3'b101) begin
        n_err++; $display("FAIL load_gnt[%0d] got gnt=%b mis=%b en=%b want 1 0 1", i, ma_gnt, ma_mis, mem_en);
      end
      ma_q.push_back(e_t[i]);
    end
    next_cyc(); idle(); settle();
  endtask

  task automatic test_store_lanes();
    ma_size_t    s_t[3]  = '{SZ_H, SZ_B, SZ_W};
    logic [31:0] a_t[3]  = '{32'h206, 32'h205, 32'h20C};
    logic [31:0] d_t[3]  = '{32'h0000_1234, 32'h0000_00AB, 32'h1122_3344};
    logic [3:0]  we_t[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd_t[3] = '{32'h1234_0000, 32'h0000_AB00, 32'h1122_3344};
    logic [31:0] wa_t[3] = '{32'h81, 32'h81, 32'h83};
    ram[12'h81] = 32'h0;
    ram[12'h83] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      drive_ma(MA_STORE, s_t[i], a_t[i], d_t[i]);
      settle();
      n_vec++;
      if ({ma_gnt, mem_en, mem_we} !== {2'b11, we_t[i]}) begin
        n_err++; $display("FAIL store_we[%0d] got gnt=%b en=%b we=%b want 1 1 %b", i, ma_gnt, mem_en, mem_we, we_t[i]);
      end
      n_vec++;
      if (mem_wdata !== wd_t[i] || mem_addr !== wa_t[i][AW-1:0]) begin
        n_err++; $display("FAIL store_data[%0d] got wdata=%h addr=%h want %h %h", i, mem_wdata, mem_addr, wd_t[i], wa_t[i]);
      end
      n_vec++;
      if (ma_rvalid !== 1'b0 && i > 0) begin
        n_err++; $display("FAIL store_no_rvalid[%0d] got %b want 0", i, ma_rvalid);
      end
    end
    // Read the stored words back through the load path.
    next_cyc();
    drive_ma(MA_LOAD, SZ_W, 32'h204, '0);
    settle();
    n_vec++;
    if (ma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL store_no_rvalid_last got %b want 0", ma_rvalid);
    end
    ma_q.push_back(32'h1234_AB00);
    next_cyc();
    drive_ma(MA_LOAD, SZ_W, 32'h20C, '0);
    settle();
    ma_q.push_back(32'h1122_3344);
    next_cyc(); idle(); settle();
  endtask

  task automatic test_misaligned();
    ram[12'h8] = 32'h0BAD_C0DE;
    next_cyc();
    if_req = 1'b1; if_addr = 32'h20;
    drive_ma(MA_LOAD, SZ_W, 32'h102, '0);
    settle();
    n_vec++;
    if ({ma_gnt, ma_mis, if_gnt, mem_en} !== 4'b1111) begin
      n_err++; $display("FAIL mis_if_gnt got ma=%b mis=%b if=%b en=%b want 1111", ma_gnt, ma_mis, if_gnt, mem_en);
    end
    n_vec++;
    if (mem_addr !== 12'h008 || mem_we !== 4'b0000) begin
      n_err++; $display("FAIL mis_if_port got addr=%h we=%b want 008 0000", mem_addr, mem_we);
    end
    if_q.push_back(32'h0BAD_C0DE);
    next_cyc();
    if_req = 1'b0;
    drive_ma(MA_LOAD, SZ_H, 32'h101, '0);
    settle();
    n_vec++;
    if (ma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL mis_no_rvalid got %b want 0", ma_rvalid);
    end
    n_vec++;
    if ({ma_gnt, ma_mis, if_gnt, mem_en} !== 4'b1100) begin
      n_err++; $display("FAIL mis_alone got ma=%b mis=%b if=%b en=%b want 1100", ma_gnt, ma_mis, if_gnt, mem_en);
    end
    next_cyc(); idle(); settle();
    n_vec++;
    if (ma_rvalid !== 1'b0) begin
      n_err++; $display("FAIL mis_alone_no_rvalid got %b want 0", ma_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic if_turn;
    ram[12'h40] = 32'h1357_9BDF;
    ram[12'h4]  = 32'hCAFE_F00D;
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      if_req = 1'b1; if_addr = 32'h10;
      drive_ma(MA_LOAD, SZ_W, 32'h100, '0);
      settle();
      if_turn = (k % 5 == 4);
      n_vec++;
      if ({if_gnt, ma_gnt} !== {if_turn, !if_turn}) begin
        n_err++; $display("FAIL starve[%0d] got if=%b ma=%b want %b %b", k, if_gnt, ma_gnt, if_turn, !if_turn);
      end
      if (if_turn) if_q.push_back(32'hCAFE_F00D);
      else         ma_q.push_back(32'h1357_9BDF);
    end
    next_cyc(); idle(); settle();
  endtask

  task automatic test_reset_mid_read();
    ram[12'h40] = 32'h2468_ACE0;
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      if_req = 1'b1; if_addr = 32'h10;
      drive_ma(MA_LOAD, SZ_W, 32'h100, '0);
      settle();
      n_vec++;
      if ({ma_gnt, if_gnt} !== 2'b10) begin
        n_err++; $display("FAIL rmid_gnt[%0d] got ma=%b if=%b want 1 0", k, ma_gnt, if_gnt);
      end
      if (k < 3) ma_q.push_back(32'h2468_ACE0);
    end
    // Counter now sits at the limit and the last grant is still in flight.
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ma_gnt, if_gnt, mem_en, mem_we, ma_rvalid, ma_rdata} !== '0) begin
      n_err++; $display("FAIL rmid_assert got gnt=%b%b en=%b we=%b v=%b d=%h want 0",
                        ma_gnt, if_gnt, mem_en, mem_we, ma_rvalid, ma_rdata);
    end
    next_cyc(); settle();
    n_vec++;
    if ({ma_rvalid, if_rvalid, ma_gnt, if_gnt, mem_addr, mem_wdata} !== '0) begin
      n_err++; $display("FAIL rmid_held got mav=%b ifv=%b gnt=%b%b addr=%h wd=%h want 0",
                        ma_rvalid, if_rvalid, ma_gnt, if_gnt, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    #1;
    n_vec++;
    if ({ma_gnt, if_gnt, ma_rvalid} !== 3'b100) begin
      n_err++; $display("FAIL rmid_release got ma=%b if=%b mav=%b want 1 0 0", ma_gnt, if_gnt, ma_rvalid);
    end
    ma_q.push_back(32'h2468_ACE0);
    next_cyc(); idle(); settle();
    next_cyc(); settle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    ram[12'h4] = 32'hCAFE_F00D;
    ram[12'h8] = 32'h0BAD_C0DE;
    idle();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_load_ext();
    test_store_lanes();
    test_misaligned();
    test_starvation();
    test_reset_mid_read();
    n_vec++;
    if (if_q.size() != 0 || ma_q.size() != 0) begin
      n_err++; $display("FAIL pending_responses got if=%0d ma=%0d want 0 0", if_q.size(), ma_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, synchronous-read data memory between instruction fetch (IF) and the memory-access (MA) stage. Grants one requester per cycle and drives the memory port with byte-lane write enables derived from `ma_size_t`. Tracks which requester owns the in-flight read and returns load data aligned and sign/zero-extended. Sits between the pipeline front/back ends and the shared BRAM.

## Interface
- `STARVE_LIMIT`, 4, consecutive denied IF cycles before IF is forced to win one cycle; legal range ≥ 1.
- `ADDR_WIDTH`, 12, word-address width of the memory port.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `if_req_i`  in  1  fetch request.
- `if_addr_i`  in  32  fetch byte address; bits [1:0] are ignored.
- `if_gnt_o`  out  1  fetch accepted this cycle.
- `if_rvalid_o`  out  1  fetch data valid, one cycle after grant.
- `if_rdata_o`  out  32  fetched word.
- `ma_req_i`  in  1  data request.
- `ma_mode_i`  in  2  `ma_mode_t`; `MA_LOAD` or `MA_STORE`; `MA_X` with req = no request.
- `ma_size_i`  in  3  `ma_size_t`.
- `ma_addr_i`  in  32  data byte address.
- `ma_wdata_i`  in  32  store data, right-justified.
- `ma_gnt_o`  out  1  data request accepted or rejected this cycle.
- `ma_misaligned_o`  out  1  accepted request is misaligned; no memory access is made.
- `ma_rvalid_o`  out  1  load data valid, one cycle after grant.
- `ma_rdata_o`  out  32  extended load result.
- `mem_en_o`  out  1  memory port enable.
- `mem_we_o`  out  4  byte write enables.
- `mem_addr_o`  out  ADDR_WIDTH  word address, taken from byte address bits [ADDR_WIDTH+1:2].
- `mem_wdata_o`  out  32  lane-shifted store data.
- `mem_rdata_i`  in  32  read data, valid one cycle after `mem_en_o` with `mem_we_o == 0`.

## Operation
- **Effective MA request:** `ma_req_i && ma_mode_i != MA_X`.
- **Priority:** MA beats IF.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `if_req_i` is high, IF wins that cycle and MA waits (`ma_gnt_o = 0`).
- **Starvation counter:**
  - Increments each cycle that `if_req_i && !if_gnt_o`.
  - Clears on `if_gnt_o` or when `!if_req_i`.
  - Saturates at `STARVE_LIMIT`.
- **Misalignment:**
  - H/HU with `addr[0] = 1` is misaligned.
  - W with `addr[1:0] != 0` is misaligned.
  - When MA wins with a misaligned request: `ma_gnt_o = 1` and `ma_misaligned_o = 1` in the same cycle, `mem_en_o = 0`, no `rvalid`.
  - IF may use the idle port that cycle if it requests (`if_gnt_o = 1`).
- **Store:**
  - `mem_we_o` is 0001, 0011 or 1111 for B, H or W, shifted left by `addr[1:0]`.
  - `mem_wdata_o = ma_wdata_i << (8 * addr[1:0])`.
  - A store produces no `rvalid`.
- **Load and fetch:**
  - Owner (NONE/IF/MA), `ma_size` and `addr[1:0]` are registered on grant.
  - Next cycle, the owner's `rvalid` is driven and `rdata` is formatted combinationally from `mem_rdata_i`.
  - Format: byte/half selected by the registered offset; B/H are sign-extended, BU/HU zero-extended, W passed through.
  - IF data is passed through unmodified.
- **Back-to-back:** a new grant may issue in the same cycle as the previous `rvalid`. Full throughput is one access per cycle.

## Timing
- Grants and `mem_*` outputs are combinational from requests and registered `starve_cnt`.
- Read latency: exactly 1 cycle from grant to `rvalid`.
- `rvalid` lasts one cycle. Requesters must not stall the response; there is no backpressure.
- **Reset** (`reset_n_i` low, asynchronous):
  - Owner resets to NONE and `starve_cnt` to 0.
  - All grants, `rvalid` and `mem_en_o` read 0 while reset is held.
  - `mem_we_o` reads 0000.
  - Data outputs read 0.
- **Reset asserted with a read in flight:** the response is dropped; no `rvalid` follows deassertion.
- Simultaneous IF and MA requests with `starve_cnt < STARVE_LIMIT`: MA wins and `starve_cnt` increments.

## Structure
- **Add to `common`:**
  - `mem_owner_t` enum: `OWNER_NONE = 2'b00`, `OWNER_IF = 2'b01`, `OWNER_MA = 2'b10`.
  - Localparam `MEM_WE_NONE = 4'b0000`.
- **Sub-module `load_align`:** combinational; inputs `mem_rdata`, `ma_size_t`, `offset[1:0]`; output the extended 32-bit word. It is reused by any future load path.
- **Top level holds:** arbitration, `starve_cnt`, owner/size/offset registers, and store lane generation.

## Test plan
- **Simultaneous requests:** `if_req` + MA `LW` to 0x100 at the same time, with `mem_rdata = 0xDEADBEEF` → `ma_gnt = 1`, `if_gnt = 0`; next cycle `ma_rvalid = 1`, `ma_rdata = 0xDEADBEEF`, `if_rvalid = 0`.
- **Load extension:** `LB` at 0x103 with `mem_rdata = 0x80xxxxxx` → `ma_rdata = 0xFFFFFF80`; `LBU` at the same address → `0x00000080`; `LHU` at 0x102 with `0xBEEFxxxx` → `0x0000BEEF`.
- **Store lanes:** `SH` of 0x1234 to 0x206 → `mem_we = 1100`, `mem_wdata = 0x12340000`, `mem_addr = 0x81`, no `rvalid`.
- **Misaligned with IF waiting:** `LW` at 0x102 with `if_req` high → `ma_gnt = 1`, `ma_misaligned = 1`, `mem_en` driven for IF only, `if_gnt = 1`, no `ma_rvalid`.
- **Starvation:** with `STARVE_LIMIT = 4`, MA and IF request continuously → MA granted 4 cycles, then IF granted in the 5th with MA held off, then the pattern repeats.
- **Reset mid-read:** grant `LW`, assert `reset_n_i` low before the next edge, release → no `ma_rvalid`, all outputs 0 during reset, `starve_cnt = 0` afterwards.
